// File: rtl/mem_axi_access.sv
// MEM-stage data-memory access unit: single-beat AXI4-Lite master with MIPS lane steering.
// Optional MEM_ALIGN_CHECK_EN: misaligned halfword/word accesses complete locally with mem_addr_err.
module mem_axi_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req_valid,
    input  logic [2:0]        mem_op,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_store_data,
    output logic              mem_stall,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_load_data,
    output logic              mem_bus_err,
    output logic              mem_addr_err,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    // state   | meaning
    // IDLE    | waiting for a memory instruction
    // RD_ADDR | AR channel valid, waiting for arready
    // RD_DATA | R channel ready, waiting for rvalid
    // WR      | AW and W valid, each dropping after its own handshake
    // WR_RESP | B channel ready, waiting for bvalid
    // DONE    | result presented to MEM/WB for one cycle
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE} state_t;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LBU = 3'b001;
    localparam logic [2:0] OP_LH  = 3'b010;
    localparam logic [2:0] OP_LHU = 3'b011;
    localparam logic [2:0] OP_LW  = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    state_t            state, state_nx;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic [DATA_W-1:0] load_q;
    logic              bus_err_q;
    logic              addr_err_q;
    logic              aw_done_q;
    logic              w_done_q;

    logic              is_store;
    logic              misalign;
    logic [DATA_W-1:0] lane_wdata;
    logic [3:0]        lane_wstrb;
    logic [DATA_W-1:0] rdata_shift;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [DATA_W-1:0] load_ext;

    assign is_store = mem_op[2] & (mem_op[1] | mem_op[0]);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = ((mem_op == OP_LH || mem_op == OP_LHU || mem_op == OP_SH) && mem_addr[0]) ||
                      ((mem_op == OP_LW || mem_op == OP_SW) && (mem_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        lane_wdata = '0;
        lane_wstrb = 4'b0000;
        case (mem_op)
            OP_SB: begin
                lane_wdata = {4{mem_store_data[7:0]}};
                lane_wstrb = 4'b0001 << mem_addr[1:0];
            end
            OP_SH: begin
                lane_wdata = {2{mem_store_data[15:0]}};
                lane_wstrb = mem_addr[1] ? 4'b1100 : 4'b0011;
            end
            OP_SW: begin
                lane_wdata = mem_store_data;
                lane_wstrb = 4'b1111;
            end
            default: ;
        endcase
    end

    // Byte/halfword extraction uses the latched address, so rdata can be consumed the cycle it arrives.
    assign rdata_shift = m_rdata >> {addr_q[1:0], 3'b000};
    assign rd_byte     = rdata_shift[7:0];
    assign rd_half     = addr_q[1] ? m_rdata[31:16] : m_rdata[15:0];

    always_comb begin
        load_ext = '0;
        case (op_q)
            OP_LB:   load_ext = {{(DATA_W-8){rd_byte[7]}}, rd_byte};
            OP_LBU:  load_ext = {{(DATA_W-8){1'b0}}, rd_byte};
            OP_LH:   load_ext = {{(DATA_W-16){rd_half[15]}}, rd_half};
            OP_LHU:  load_ext = {{(DATA_W-16){1'b0}}, rd_half};
            OP_LW:   load_ext = m_rdata;
            default: load_ext = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= 4'b0000;
            load_q     <= '0;
            bus_err_q  <= 1'b0;
            addr_err_q <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (mem_req_valid) begin
                        op_q       <= mem_op;
                        addr_q     <= mem_addr;
                        wdata_q    <= (is_store && !misalign) ? lane_wdata : '0;
                        wstrb_q    <= (is_store && !misalign) ? lane_wstrb : 4'b0000;
                        load_q     <= '0;
                        bus_err_q  <= 1'b0;
                        addr_err_q <= misalign;
                        aw_done_q  <= 1'b0;
                        w_done_q   <= 1'b0;
                    end
                end
                RD_DATA: begin
                    if (m_rvalid) begin
                        load_q    <= load_ext;
                        bus_err_q <= (m_rresp != 2'b00);
                    end
                end
                WR: begin
                    if (m_awready) aw_done_q <= 1'b1;
                    if (m_wready)  w_done_q  <= 1'b1;
                end
                WR_RESP: begin
                    if (m_bvalid) bus_err_q <= (m_bresp != 2'b00);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        mem_done  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req_valid) begin
                    if (misalign)      state_nx = DONE;
                    else if (is_store) state_nx = WR;
                    else               state_nx = RD_ADDR;
                end
            end
            RD_ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) state_nx = RD_DATA;
            end
            RD_DATA: begin
                m_rready = 1'b1;
                if (m_rvalid) state_nx = DONE;
            end
            WR: begin
                m_awvalid = !aw_done_q;
                m_wvalid  = !w_done_q;
                if ((aw_done_q || m_awready) && (w_done_q || m_wready)) state_nx = WR_RESP;
            end
            WR_RESP: begin
                m_bready = 1'b1;
                if (m_bvalid) state_nx = DONE;
            end
            DONE: begin
                mem_done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign mem_stall     = mem_req_valid && (state != DONE);
    assign mem_load_data = (state == DONE) ? load_q : '0;
    assign mem_bus_err   = (state == DONE) && bus_err_q;
    assign mem_addr_err  = (state == DONE) && addr_err_q;

    assign m_araddr = {addr_q[ADDR_W-1:2], 2'b00};
    assign m_awaddr = {addr_q[ADDR_W-1:2], 2'b00};
    assign m_wdata  = wdata_q;
    assign m_wstrb  = wstrb_q;

endmodule

// File: tb/tb_mem_axi_access.sv
// Directed bench for mem_axi_access: vector table of zero-wait accesses plus hand-written wait/reset/alignment cases.
module tb_mem_axi_access;

    logic        clk;
    logic        rst;
    logic        mem_req_valid;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_store_data;
    logic        mem_stall;
    logic        mem_done;
    logic [31:0] mem_load_data;
    logic        mem_bus_err;
    logic        mem_addr_err;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    mem_axi_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_req_valid(mem_req_valid), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_store_data(mem_store_data), .mem_stall(mem_stall), .mem_done(mem_done),
        .mem_load_data(mem_load_data), .mem_bus_err(mem_bus_err), .mem_addr_err(mem_addr_err),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // results of the most recent run_txn
    int          r_done_cycle;
    int          r_stall_cnt;
    int          r_aw_cycles;
    logic        r_bus_act;
    logic [31:0] r_baddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_load;
    logic        r_bus_err;
    logic        r_addr_err;

    task automatic clear_slave();
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    endtask

    // Entered at posedge+1 of request cycle 0; returns at posedge+1 of the cycle after mem_done,
    // still holding mem_req_valid so a following call is back-to-back.
    task automatic run_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] rdata, input logic [1:0] resp,
                           input int ar_d, input int r_d, input int aw_d, input int w_d, input int b_d);
        int ar_w = 0, r_w = 0, aw_w = 0, w_w = 0, b_w = 0;
        bit r_pend = 0, b_pend = 0, b_started = 0, aw_ok = 0, w_ok = 0, fin = 0;
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
        mem_req_valid = 1'b1; mem_op = op; mem_addr = addr; mem_store_data = sdata;
        r_done_cycle = -1; r_stall_cnt = 0; r_aw_cycles = 0; r_bus_act = 1'b0;
        r_baddr = '0; r_wdata = '0; r_wstrb = '0; r_load = '0; r_bus_err = 1'b0; r_addr_err = 1'b0;
        for (int c = 0; c < 60 && !fin; c++) begin
            m_arready = m_arvalid && (ar_w >= ar_d);
            m_rvalid  = r_pend && (r_w >= r_d);
            m_rdata   = rdata; m_rresp = resp;
            m_awready = m_awvalid && (aw_w >= aw_d);
            m_wready  = m_wvalid && (w_w >= w_d);
            m_bvalid  = b_pend && (b_w >= b_d);
            m_bresp   = resp;
            #1;
            if (m_arvalid || m_awvalid || m_wvalid) r_bus_act = 1'b1;
            if (mem_stall) r_stall_cnt++;
            if (m_awvalid) r_aw_cycles++;
            ar_hs = m_arvalid && m_arready;
            r_hs  = m_rvalid && m_rready;
            aw_hs = m_awvalid && m_awready;
            w_hs  = m_wvalid && m_wready;
            b_hs  = m_bvalid && m_bready;
            if (ar_hs) r_baddr = m_araddr;
            else if (m_arvalid) ar_w++;
            if (r_pend && !r_hs) r_w++;
            if (r_hs) r_pend = 0;
            if (ar_hs) r_pend = 1;
            if (aw_hs) begin r_baddr = m_awaddr; aw_ok = 1; end
            else if (m_awvalid) aw_w++;
            if (w_hs) begin r_wdata = m_wdata; r_wstrb = m_wstrb; w_ok = 1; end
            else if (m_wvalid) w_w++;
            if (b_pend && !b_hs) b_w++;
            if (b_hs) b_pend = 0;
            if (aw_ok && w_ok && !b_started) begin b_pend = 1; b_started = 1; end
            if (mem_done) begin
                r_done_cycle = c; r_load = mem_load_data;
                r_bus_err = mem_bus_err; r_addr_err = mem_addr_err; fin = 1;
            end
            @(posedge clk); #1;
        end
        clear_slave();
        if (!fin) $display("FAIL txn_timeout: got no mem_done expected mem_done within 60 cycles");
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [31:0] exp_load;
        logic [31:0] exp_baddr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{"lw_100",   3'b100, 32'h100, 32'h0,        32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 32'h100, 32'h0,        4'b0000, 1'b0};
        vecs[1]  = '{"lb_103",   3'b000, 32'h103, 32'h0,        32'h80123456, 2'b00, 32'hFFFFFF80, 32'h100, 32'h0,        4'b0000, 1'b0};
        vecs[2]  = '{"lbu_103",  3'b001, 32'h103, 32'h0,        32'h80123456, 2'b00, 32'h00000080, 32'h100, 32'h0,        4'b0000, 1'b0};
        vecs[3]  = '{"lh_102",   3'b010, 32'h102, 32'h0,        32'h80123456, 2'b00, 32'hFFFF8012, 32'h100, 32'h0,        4'b0000, 1'b0};
        vecs[4]  = '{"lhu_102",  3'b011, 32'h102, 32'h0,        32'h80123456, 2'b00, 32'h00008012, 32'h100, 32'h0,        4'b0000, 1'b0};
        vecs[5]  = '{"lhu_100",  3'b011, 32'h100, 32'h0,        32'h8012F654, 2'b00, 32'h0000F654, 32'h100, 32'h0,        4'b0000, 1'b0};
        vecs[6]  = '{"lb_101",   3'b000, 32'h101, 32'h0,        32'h00007F00, 2'b00, 32'h0000007F, 32'h100, 32'h0,        4'b0000, 1'b0};
        vecs[7]  = '{"sb_201",   3'b101, 32'h201, 32'h000000AB, 32'h0,        2'b00, 32'h0,        32'h200, 32'hABABABAB, 4'b0010, 1'b0};
        vecs[8]  = '{"sh_202",   3'b110, 32'h202, 32'h00001234, 32'h0,        2'b00, 32'h0,        32'h200, 32'h12341234, 4'b1100, 1'b0};
        vecs[9]  = '{"sw_300",   3'b111, 32'h300, 32'hCAFEF00D, 32'h0,        2'b00, 32'h0,        32'h300, 32'hCAFEF00D, 4'b1111, 1'b0};
        vecs[10] = '{"sb_203",   3'b101, 32'h203, 32'h12345677, 32'h0,        2'b00, 32'h0,        32'h200, 32'h77777777, 4'b1000, 1'b0};
        vecs[11] = '{"lw_slverr",3'b100, 32'h40C, 32'h0,        32'h0BADF00D, 2'b10, 32'h0BADF00D, 32'h40C, 32'h0,        4'b0000, 1'b1};
    end

    logic [31:0] outs;

    initial begin
        rst = 1'b1; mem_req_valid = 1'b0; mem_op = 3'b000; mem_addr = '0; mem_store_data = '0;
        clear_slave();
        repeat (3) @(posedge clk);
        #1;
        outs = {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, mem_done, mem_stall, mem_bus_err, mem_addr_err, m_wstrb};
        check("reset_ctrl", outs, 32'h0);
        check("reset_araddr", m_araddr, 32'h0);
        check("reset_load", mem_load_data, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // back-to-back zero-wait vectors
        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].op, vecs[i].addr, vecs[i].sdata, vecs[i].rdata, vecs[i].resp, 0, 0, 0, 0, 0);
            check({vecs[i].name, "_done_cycle"}, r_done_cycle, 32'd3);
            check({vecs[i].name, "_stall"}, r_stall_cnt, 32'd3);
            check({vecs[i].name, "_baddr"}, r_baddr, vecs[i].exp_baddr);
            check({vecs[i].name, "_load"}, r_load, vecs[i].exp_load);
            check({vecs[i].name, "_bus_err"}, {31'b0, r_bus_err}, {31'b0, vecs[i].exp_err});
            check({vecs[i].name, "_addr_err"}, {31'b0, r_addr_err}, 32'h0);
            if (vecs[i].op[2] && vecs[i].op[1:0] != 2'b00) begin
                check({vecs[i].name, "_wdata"}, r_wdata, vecs[i].exp_wdata);
                check({vecs[i].name, "_wstrb"}, {28'b0, r_wstrb}, {28'b0, vecs[i].exp_wstrb});
            end
        end
        mem_req_valid = 1'b0;
        @(posedge clk); #1;

        // store: AW ready immediately, W ready cycle 4, BVALID cycle 6 with SLVERR
        run_txn(3'b110, 32'h200, 32'hFFFF5A5A, 32'h0, 2'b10, 0, 0, 0, 3, 1);
        check("st_wait_done_cycle", r_done_cycle, 32'd7);
        check("st_wait_aw_cycles", r_aw_cycles, 32'd1);
        check("st_wait_stall", r_stall_cnt, 32'd7);
        check("st_wait_bus_err", {31'b0, r_bus_err}, 32'h1);
        check("st_wait_wdata", r_wdata, 32'h5A5A5A5A);
        check("st_wait_wstrb", {28'b0, r_wstrb}, 32'h3);
        mem_req_valid = 1'b0;
        @(posedge clk); #1;

        // load with AR and R waits
        run_txn(3'b100, 32'h500, 32'h0, 32'h13579BDF, 2'b00, 2, 1, 0, 0, 0);
        check("ld_wait_done_cycle", r_done_cycle, 32'd6);
        check("ld_wait_stall", r_stall_cnt, 32'd6);
        check("ld_wait_load", r_load, 32'h13579BDF);

        // mid-transaction reset during RD_DATA
        mem_op = 3'b100; mem_addr = 32'h400; mem_req_valid = 1'b1;
        @(posedge clk); #1;
        m_arready = 1'b1;
        @(posedge clk); #1;
        m_arready = 1'b0;
        check("rst_mid_in_rd_data", {31'b0, m_rready}, 32'h1);
        rst = 1'b1; mem_req_valid = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        outs = {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, mem_done, mem_stall, mem_bus_err, mem_addr_err, m_wstrb};
        check("rst_mid_ctrl", outs, 32'h0);
        check("rst_mid_araddr", m_araddr, 32'h0);
        check("rst_mid_awaddr", m_awaddr, 32'h0);
        check("rst_mid_load", mem_load_data, 32'h0);
        rst = 1'b0; clear_slave();
        outs = '0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (mem_done || m_arvalid || m_rready) outs = outs + 1;
        end
        check("rst_mid_no_resp", outs, 32'h0);

        // misaligned word access
        run_txn(3'b100, 32'h102, 32'h0, 32'h11223344, 2'b00, 0, 0, 0, 0, 0);
`ifdef MEM_ALIGN_CHECK_EN
        check("mis_lw_done_cycle", r_done_cycle, 32'd1);
        check("mis_lw_addr_err", {31'b0, r_addr_err}, 32'h1);
        check("mis_lw_load", r_load, 32'h0);
        check("mis_lw_bus_act", {31'b0, r_bus_act}, 32'h0);
        check("mis_lw_stall", r_stall_cnt, 32'd1);
`else
        check("mis_lw_done_cycle", r_done_cycle, 32'd3);
        check("mis_lw_addr_err", {31'b0, r_addr_err}, 32'h0);
        check("mis_lw_load", r_load, 32'h11223344);
        check("mis_lw_baddr", r_baddr, 32'h100);
`endif
        mem_req_valid = 1'b0;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
